// File: rtl/sccb_master.sv
// SCCB/I2C camera-config master: 16-bit register address, 8-bit data, two-phase SCCB read.
// Optional macro SCCB_ACK_CHECK_EN: honour slave NACKs (abort to STOP and flag rsp_err).
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | bus free, cmd_ready high, waiting for a command
// S_START | START condition, 2 quarters (SDA released, then SDA low)
// S_TX    | shifting one master byte out, MSB first
// S_ACK   | 9th bit of a master byte, SDA released for slave ACK
// S_RX    | shifting the read data byte in from the slave
// S_MACK  | 9th bit of the read byte, master NACK (SDA released)
// S_STOP  | STOP condition, 3 quarters (SDA low, SCL high, SDA released)
// S_DONE  | one-cycle response pulse
module sccb_master #(
  parameter int          CLK_FREQ = 50_000_000,
  parameter int          SCL_FREQ = 100_000,
  parameter logic [6:0]  DEV_ADDR = 7'h3C
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rw,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        scl,
  output logic        sda_o,
  output logic        sda_t,
  input  logic        sda_i
);

  localparam int QDIV_RAW = CLK_FREQ / (4 * SCL_FREQ);
  localparam int QDIV     = (QDIV_RAW < 1) ? 1 : QDIV_RAW;
  localparam int QW       = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam logic [QW-1:0] QLOAD = QW'(QDIV - 1);
  localparam logic [7:0] WR_BYTE = {DEV_ADDR, 1'b0};
  localparam logic [7:0] RD_BYTE = {DEV_ADDR, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_TX, S_ACK, S_RX, S_MACK, S_STOP, S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     ph_q, ph_d;
  logic [QW-1:0]  qcnt_q, qcnt_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [1:0]     byte_idx_q, byte_idx_d;
  logic [7:0]     shreg_q, shreg_d;
  logic           rw_q, rw_d;
  logic [15:0]    addr_q, addr_d;
  logic [7:0]     wdata_q, wdata_d;
  logic           rd_ph2_q, rd_ph2_d;
  logic [7:0]     rdata_q, rdata_d;
  logic           scl_q, scl_d;
  logic           sda_t_q, sda_t_d;
  logic           ready_q, ready_d;
  logic           busy_q, busy_d;
  logic           rsp_valid_q, rsp_valid_d;

  logic           tick;
  logic [1:0]     last_ph;
  logic [1:0]     idx_nx;
  logic [1:0]     last_idx;
  logic [7:0]     nxt_byte;
  logic           nak;

`ifdef SCCB_ACK_CHECK_EN
  logic nak_q, nak_d;
  logic err_q, err_d;
  assign nak     = nak_q;
  assign rsp_err = err_q;
`else
  assign nak     = 1'b0;
  assign rsp_err = 1'b0;
`endif

  assign tick     = (qcnt_q == '0);
  assign idx_nx   = byte_idx_q + 2'd1;
  assign last_idx = rw_q ? 2'd2 : 2'd3;

  always_comb begin
    last_ph = 2'd3;
    if (state_q == S_START)     last_ph = 2'd1;
    else if (state_q == S_STOP) last_ph = 2'd2;
  end

  always_comb begin
    case (idx_nx)
      2'd1:    nxt_byte = addr_q[15:8];
      2'd2:    nxt_byte = addr_q[7:0];
      2'd3:    nxt_byte = wdata_q;
      default: nxt_byte = WR_BYTE;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    qcnt_d     = qcnt_q;
    bit_cnt_d  = bit_cnt_q;
    byte_idx_d = byte_idx_q;
    shreg_d    = shreg_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_ph2_d   = rd_ph2_q;
    rdata_d    = rdata_q;
`ifdef SCCB_ACK_CHECK_EN
    nak_d      = nak_q;
    err_d      = err_q;
`endif

    case (state_q)
      S_IDLE: begin
        ph_d   = 2'd0;
        qcnt_d = QLOAD;
        if (cmd_valid && ready_q) begin
          rw_d       = cmd_rw;
          addr_d     = cmd_addr;
          wdata_d    = cmd_wdata;
          rd_ph2_d   = 1'b0;
          byte_idx_d = 2'd0;
          bit_cnt_d  = 3'd0;
`ifdef SCCB_ACK_CHECK_EN
          nak_d      = 1'b0;
          err_d      = 1'b0;
`endif
          state_d    = S_START;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: begin
        if (!tick) begin
          qcnt_d = qcnt_q - QW'(1);
        end else begin
          qcnt_d = QLOAD;
          ph_d   = ph_q + 2'd1;

          // sda_i is only looked at mid-high of ACK/RX bits
          if (ph_q == 2'd2) begin
            if (state_q == S_RX) shreg_d = {shreg_q[6:0], sda_i};
`ifdef SCCB_ACK_CHECK_EN
            if (state_q == S_ACK) begin
              nak_d = sda_i;
              if (sda_i) err_d = 1'b1;
            end
`endif
          end

          if (ph_q == last_ph) begin
            ph_d = 2'd0;
            case (state_q)
              S_START: begin
                state_d    = S_TX;
                bit_cnt_d  = 3'd0;
                byte_idx_d = 2'd0;
                shreg_d    = rd_ph2_q ? RD_BYTE : WR_BYTE;
              end
              S_TX: begin
                if (bit_cnt_q == 3'd7) begin
                  state_d = S_ACK;
                end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  shreg_d   = {shreg_q[6:0], 1'b0};
                end
              end
              S_ACK: begin
                bit_cnt_d = 3'd0;
                if (nak) begin
                  state_d = S_STOP;
                end else if (rd_ph2_q) begin
                  state_d = S_RX;
                end else if (byte_idx_q == last_idx) begin
                  state_d = S_STOP;
                end else begin
                  byte_idx_d = idx_nx;
                  shreg_d    = nxt_byte;
                  state_d    = S_TX;
                end
              end
              S_RX: begin
                if (bit_cnt_q == 3'd7) begin
                  rdata_d = shreg_q;
                  state_d = S_MACK;
                end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                end
              end
              S_MACK: state_d = S_STOP;
              S_STOP: begin
                // read address phase done: second transaction carries the data
                if (rw_q && !rd_ph2_q && !nak) begin
                  rd_ph2_d = 1'b1;
                  state_d  = S_START;
                end else begin
                  state_d  = S_DONE;
                end
              end
              default: state_d = S_IDLE;
            endcase
          end
        end
      end
    endcase
  end

  always_comb begin
    scl_d   = 1'b1;
    sda_t_d = 1'b1;
    case (state_q)
      S_START: sda_t_d = (ph_q == 2'd0);
      S_TX: begin
        scl_d   = (ph_q == 2'd1) || (ph_q == 2'd2);
        sda_t_d = shreg_q[7];
      end
      S_ACK, S_RX, S_MACK: scl_d = (ph_q == 2'd1) || (ph_q == 2'd2);
      S_STOP: begin
        scl_d   = (ph_q != 2'd0);
        sda_t_d = (ph_q == 2'd2);
      end
      default: ;
    endcase
  end

  assign ready_d     = (state_d == S_IDLE);
  assign busy_d      = (state_d != S_IDLE);
  assign rsp_valid_d = (state_d == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ph_q        <= 2'd0;
      qcnt_q      <= QLOAD;
      bit_cnt_q   <= 3'd0;
      byte_idx_q  <= 2'd0;
      shreg_q     <= 8'h00;
      rw_q        <= 1'b0;
      addr_q      <= 16'h0000;
      wdata_q     <= 8'h00;
      rd_ph2_q    <= 1'b0;
      rdata_q     <= 8'h00;
      scl_q       <= 1'b1;
      sda_t_q     <= 1'b1;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      qcnt_q      <= qcnt_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_idx_q  <= byte_idx_d;
      shreg_q     <= shreg_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_ph2_q    <= rd_ph2_d;
      rdata_q     <= rdata_d;
      scl_q       <= scl_d;
      sda_t_q     <= sda_t_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

`ifdef SCCB_ACK_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nak_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      nak_q <= nak_d;
      err_q <= err_d;
    end
  end
`endif

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign scl       = scl_q;
  assign sda_t     = sda_t_q;
  assign sda_o     = 1'b0;

endmodule

// File: tb/tb_sccb_master.sv
// Scoreboard bench for sccb_master: bus decoder + slave model checks SDA traffic,
// response monitor checks rsp_* against queued expectations.
module tb_sccb_master;
  localparam int CLK_FREQ = 4_000_000;
  localparam int SCL_FREQ = 100_000;
  localparam int QDIV     = 10;
  localparam int EV_START = -1;
  localparam int EV_STOP  = -2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rw;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        scl;
  logic        sda_o;
  logic        sda_t;
  logic        sda_line;
  logic        slv_low;

  always #5 clk = ~clk;

  assign sda_line = (sda_t ? 1'b1 : sda_o) & ~slv_low;

  sccb_master #(.CLK_FREQ(CLK_FREQ), .SCL_FREQ(SCL_FREQ), .DEV_ADDR(7'h3C)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .scl(scl), .sda_o(sda_o), .sda_t(sda_t), .sda_i(sda_line)
  );

  typedef struct { logic [7:0] rdata; logic err; } rsp_t;

  int   checks = 0;
  int   errors = 0;
  int   exp_bus[$];
  rsp_t exp_rsp[$];

  int         nak_idx = -1;
  logic [7:0] tx_byte = 8'h00;
  int         accept_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=missing required=present", name);
  endtask

  task automatic bus_event(input int ev);
    if (exp_bus.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL bus_extra actual=%0h required=none", ev);
    end else begin
      check("bus", ev, exp_bus.pop_front());
    end
  endtask

  // bus decoder and slave model
  initial begin
    logic prev_scl, prev_sda, slave_tx, meas;
    logic [7:0] cur_byte;
    int bitn, byte_no, hcnt;
    prev_scl = 1'b1; prev_sda = 1'b1; slave_tx = 1'b0; meas = 1'b0;
    cur_byte = 8'h00; bitn = 0; byte_no = 0; hcnt = 0;
    slv_low = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        slv_low = 1'b0; bitn = 0; byte_no = 0; slave_tx = 1'b0; meas = 1'b0;
      end else if (prev_scl && scl && prev_sda && !sda_line) begin
        bus_event(EV_START);
        bitn = 0; byte_no = 0; slave_tx = 1'b0; meas = 1'b0;
      end else if (prev_scl && scl && !prev_sda && sda_line) begin
        bus_event(EV_STOP);
        meas = 1'b0; slv_low = 1'b0;
      end else if (!prev_scl && scl) begin
        meas = 1'b1; hcnt = 1;
        if (bitn < 8) begin
          cur_byte = {cur_byte[6:0], sda_line};
          bitn++;
        end else begin
          bus_event({23'd0, sda_line, cur_byte});
          slave_tx = (byte_no == 0) && (cur_byte == 8'h79) && !sda_line;
          byte_no++;
          bitn = 0;
        end
      end else if (prev_scl && !scl) begin
        if (meas) check("scl_high", hcnt, 2 * QDIV);
        meas = 1'b0;
        if (bitn == 8) slv_low = slave_tx ? 1'b0 : (byte_no != nak_idx);
        else           slv_low = slave_tx ? ~tx_byte[7 - bitn] : 1'b0;
      end else if (scl && meas) begin
        hcnt++;
      end
      prev_scl = scl;
      prev_sda = sda_line;
    end
  end

  // response monitor
  initial begin
    logic prev_rsp;
    rsp_t e;
    prev_rsp = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_rsp = 1'b0;
      end else begin
        if (prev_rsp) check("busy_after_rsp", busy, 0);
        if (rsp_valid) begin
          if (exp_rsp.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_extra actual=%0h required=none", rsp_rdata);
          end else begin
            e = exp_rsp.pop_front();
            check("rsp_rdata", rsp_rdata, e.rdata);
            check("rsp_err", rsp_err, e.err);
          end
          check("ready_in_done", cmd_ready, 0);
          check("busy_in_done", busy, 1);
          check("sda_o", sda_o, 0);
        end
        prev_rsp = rsp_valid;
        if (cmd_valid && cmd_ready) accept_cnt++;
      end
    end
  end

  task automatic push_rsp(input logic [7:0] rd, input logic er);
    rsp_t r;
    r.rdata = rd;
    r.err   = er;
    exp_rsp.push_back(r);
  endtask

  task automatic push_write(input logic [15:0] a, input logic [7:0] d);
    exp_bus.push_back(EV_START);
    exp_bus.push_back(32'h078);
    exp_bus.push_back({24'd0, a[15:8]});
    exp_bus.push_back({24'd0, a[7:0]});
    exp_bus.push_back({24'd0, d});
    exp_bus.push_back(EV_STOP);
  endtask

  task automatic push_read(input logic [15:0] a, input logic [7:0] d);
    exp_bus.push_back(EV_START);
    exp_bus.push_back(32'h078);
    exp_bus.push_back({24'd0, a[15:8]});
    exp_bus.push_back({24'd0, a[7:0]});
    exp_bus.push_back(EV_STOP);
    exp_bus.push_back(EV_START);
    exp_bus.push_back(32'h079);
    exp_bus.push_back({23'd0, 1'b1, d});
    exp_bus.push_back(EV_STOP);
  endtask

  task automatic issue(input logic rw, input logic [15:0] a, input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    cmd_rw = rw; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1'b1;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_addr = 16'hDEAD; cmd_wdata = 8'hEE;
    if (!ok) fail_now("accept_timeout");
  endtask

  task automatic wait_rsp();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20000 && !ok; i++) begin
      @(negedge clk);
      if (rsp_valid) ok = 1'b1;
    end
    if (!ok) fail_now("rsp_timeout");
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0, n;
    rst = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = 16'h0; cmd_wdata = 8'h0;
    repeat (3) @(negedge clk);
    check("rst_ready", cmd_ready, 0);
    check("rst_scl", scl, 1);
    check("rst_sda_t", sda_t, 1);
    @(posedge clk); #1 rst = 1'b0;
    repeat (10) @(negedge clk);
    check("idle_scl", scl, 1);
    check("idle_sda_t", sda_t, 1);
    check("idle_ready", cmd_ready, 1);
    check("idle_busy", busy, 0);
    check("idle_rsp_valid", rsp_valid, 0);
    check("idle_rdata", rsp_rdata, 0);
    check("idle_err", rsp_err, 0);
    check("idle_sda_o", sda_o, 0);

    push_write(16'h3008, 8'h82);
    push_rsp(8'h00, 1'b0);
    issue(1'b0, 16'h3008, 8'h82);
    wait_rsp();

    tx_byte = 8'h56;
    push_read(16'h300A, 8'h56);
    push_rsp(8'h56, 1'b0);
    issue(1'b1, 16'h300A, 8'h00);
    wait_rsp();

    nak_idx = 1;
    exp_bus.push_back(EV_START);
    exp_bus.push_back(32'h078);
    exp_bus.push_back(32'h130);
`ifdef SCCB_ACK_CHECK_EN
    exp_bus.push_back(EV_STOP);
    push_rsp(8'h56, 1'b1);
`else
    exp_bus.push_back(32'h008);
    exp_bus.push_back(32'h082);
    exp_bus.push_back(EV_STOP);
    push_rsp(8'h56, 1'b0);
`endif
    issue(1'b0, 16'h3008, 8'h82);
    wait_rsp();
    nak_idx = -1;

    // cmd_valid held across two transactions
    push_write(16'h1234, 8'hA5);
    push_rsp(8'h56, 1'b0);
    push_write(16'h1234, 8'hA5);
    push_rsp(8'h56, 1'b0);
    acc0 = accept_cnt;
    n = 0;
    @(posedge clk); #1;
    cmd_rw = 1'b0; cmd_addr = 16'h1234; cmd_wdata = 8'hA5; cmd_valid = 1'b1;
    for (int i = 0; i < 20000 && n < 2; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        n++;
        if (n == 2) cmd_valid = 1'b0;
      end
    end
    if (n < 2) begin
      cmd_valid = 1'b0;
      fail_now("held_rsp_timeout");
    end
    repeat (50) @(negedge clk);
    check("held_accepts", accept_cnt - acc0, 2);
    check("held_bus_drained", exp_bus.size(), 0);

    // reset in the middle of the address-high byte of a write
    push_write(16'hFFEE, 8'h01);
    push_rsp(8'h00, 1'b0);
    issue(1'b0, 16'hFFEE, 8'h01);
    repeat (520) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("midrst_scl", scl, 1);
    check("midrst_sda_t", sda_t, 1);
    check("midrst_busy", busy, 0);
    exp_bus.delete();
    exp_rsp.delete();
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(negedge clk);

    push_write(16'hFFEE, 8'h01);
    push_rsp(8'h00, 1'b0);
    issue(1'b0, 16'hFFEE, 8'h01);
    wait_rsp();

    tx_byte = 8'h9A;
    push_read(16'h0102, 8'h9A);
    push_rsp(8'h9A, 1'b0);
    issue(1'b1, 16'h0102, 8'h00);
    wait_rsp();

    repeat (20) @(negedge clk);
    check("bus_queue_empty", exp_bus.size(), 0);
    check("rsp_queue_empty", exp_rsp.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
